// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared CDB sizing, multiplier latency and select-bus type for the CDB slot scheduler,
// the cdb broadcast mux and the multiplier pipeline.
package cdb_slot_scheduler_pkg;

  localparam int CDB_N         = 2;
  localparam int NUM_FU_ALU    = 2;
  localparam int NUM_FU_BRANCH = 1;
  localparam int NUM_FU_MEM    = 2;
  localparam int NUM_FU_SC     = NUM_FU_ALU + NUM_FU_BRANCH + NUM_FU_MEM;
  // Bit 0 of every select word is the multiplier, the rest are single-cycle FUs
  localparam int NUM_FU_TOTAL  = NUM_FU_SC + 1;
  localparam int MULT_LAT      = 4;

  typedef logic [CDB_N-1:0][NUM_FU_TOTAL-1:0] cdb_sel_t;

  function automatic int unsigned rr_advance(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_slot_scheduler_rr_multi_sel.sv
// Combinational round-robin picker: grants up to `count` requests scanning upward from
// `start` with wrap, and reports which request landed in each output slot.
module cdb_slot_scheduler_rr_multi_sel #(
  parameter int WIDTH = 5,
  parameter int SLOTS = 2,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(SLOTS + 1)
) (
  input  logic [WIDTH-1:0]             req,
  input  logic [IDX_W-1:0]             start,
  input  logic [CNT_W-1:0]             count,
  output logic [WIDTH-1:0]             gnt,
  output logic [SLOTS-1:0][WIDTH-1:0]  slot_sel,
  output logic [IDX_W-1:0]             last,
  output logic                         any
);

  logic [CNT_W-1:0] taken;
  logic [IDX_W:0]   idx_wide;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt      = '0;
    slot_sel = '0;
    last     = '0;
    any      = 1'b0;
    taken    = '0;
    idx_wide = '0;
    idx      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx_wide = {1'b0, start} + (IDX_W+1)'(i);
      if (idx_wide >= (IDX_W+1)'(WIDTH)) begin
        idx_wide = idx_wide - (IDX_W+1)'(WIDTH);
      end
      idx = idx_wide[IDX_W-1:0];
      if (req[idx] && (taken < count)) begin
        gnt[idx] = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
          if (taken == CNT_W'(s)) begin
            slot_sel[s][idx] = 1'b1;
          end
        end
        last  = idx;
        any   = 1'b1;
        taken = taken + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// Allocates next-cycle CDB slots: multiplier results are reserved MULT_LAT cycles ahead
// and always take slot 0; single-cycle FUs share the remaining slots round-robin.
module cdb_slot_scheduler
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int N        = CDB_N,
  parameter int NUM_REQ  = NUM_FU_SC,
  parameter int MULT_LAT = cdb_slot_scheduler_pkg::MULT_LAT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic                          mult_req,
  input  logic                          flush,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          mult_gnt,
  output logic [$clog2(N+1)-1:0]        free_slots,
  output logic [N-1:0][NUM_REQ:0]       cdb_sel
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [NUM_REQ:0] MULT_ONEHOT = (NUM_REQ+1)'(1);

  logic [MULT_LAT-1:1]          resv_reg, resv_next;
  logic [PTR_W-1:0]             rr_ptr_reg, rr_ptr_next;
  logic [N-1:0][NUM_REQ:0]      cdb_sel_reg, cdb_sel_next;

  logic                         active;
  logic [CNT_W-1:0]             grant_count;
  logic [N-1:0][NUM_REQ-1:0]    slot_sel;
  logic [PTR_W-1:0]             last_idx;
  logic                         any_gnt;

  // Flush and reset both suppress every grant issued this cycle
  assign active      = reset & ~flush;
  assign free_slots  = reset ? (CNT_W'(N) - CNT_W'(resv_reg[1])) : CNT_W'(N);
  assign grant_count = active ? free_slots : '0;
  assign mult_gnt    = active & mult_req;

  cdb_slot_scheduler_rr_multi_sel #(
    .WIDTH (NUM_REQ),
    .SLOTS (N)
  ) u_sel (
    .req      (req),
    .start    (rr_ptr_reg),
    .count    (grant_count),
    .gnt      (gnt),
    .slot_sel (slot_sel),
    .last     (last_idx),
    .any      (any_gnt)
  );

  always_comb begin
    resv_next = '0;
    for (int k = 1; k < MULT_LAT - 1; k++) begin
      resv_next[k] = resv_reg[k+1];
    end
    resv_next[MULT_LAT-1] = mult_gnt;
  end

  assign rr_ptr_next = any_gnt ? PTR_W'(rr_advance(32'(last_idx), NUM_REQ)) : rr_ptr_reg;

  // A due multiply owns slot 0, pushing single-cycle grants up by one slot
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_slot
    if (gi == 0) begin : g_first
      assign cdb_sel_next[gi] = !active    ? '0 :
                                resv_reg[1] ? MULT_ONEHOT : {slot_sel[gi], 1'b0};
    end else begin : g_rest
      assign cdb_sel_next[gi] = !active    ? '0 :
                                resv_reg[1] ? {slot_sel[gi-1], 1'b0} : {slot_sel[gi], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resv_reg    <= '0;
      rr_ptr_reg  <= '0;
      cdb_sel_reg <= '0;
    end else begin
      resv_reg    <= flush ? '0 : resv_next;
      rr_ptr_reg  <= rr_ptr_next;
      cdb_sel_reg <= cdb_sel_next;
    end
  end

  assign cdb_sel = cdb_sel_reg;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench for cdb_slot_scheduler (N=2, NUM_REQ=5, MULT_LAT=4) with hand-computed
// grants, free-slot counts, select words and round-robin pointer per step.
module tb_cdb_slot_scheduler;

  logic              clock;
  logic              reset;
  logic [4:0]        req;
  logic              mult_req;
  logic              flush;
  logic [4:0]        gnt;
  logic              mult_gnt;
  logic [1:0]        free_slots;
  logic [1:0][5:0]   cdb_sel;

  int vectors = 0;
  int errors  = 0;

  cdb_slot_scheduler #(
    .N        (2),
    .NUM_REQ  (5),
    .MULT_LAT (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .mult_req   (mult_req),
    .flush      (flush),
    .gnt        (gnt),
    .mult_gnt   (mult_gnt),
    .free_slots (free_slots),
    .cdb_sel    (cdb_sel)
  );

  logic [2:0] rr_obs;
  assign rr_obs = dut.rr_ptr_reg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, check combinational outputs, then registered state
  task automatic step(input string tag, input logic rst_n, input logic [4:0] r,
                      input logic m, input logic f, input logic [4:0] eg,
                      input logic emg, input logic [1:0] efs, input logic [11:0] ecs,
                      input logic [2:0] err);
    reset    = rst_n;
    req      = r;
    mult_req = m;
    flush    = f;
    #2;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".mult_gnt"}, 32'(mult_gnt), 32'(emg));
    chk({tag, ".free_slots"}, 32'(free_slots), 32'(efs));
    @(posedge clock);
    #1;
    chk({tag, ".cdb_sel"}, 32'(cdb_sel), 32'(ecs));
    chk({tag, ".rr_ptr"}, 32'(rr_obs), 32'(err));
    $display("step %-6s req=%b mult=%b flush=%b gnt=%b mgnt=%b free=%0d cdb_sel=%h rr=%0d",
             tag, r, m, f, gnt, mult_gnt, free_slots, cdb_sel, rr_obs);
  endtask

  initial begin
    reset = 1'b0; req = '0; mult_req = 1'b0; flush = 1'b0;
    // reset held with everything requesting
    step("rst0",  1'b0, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("rst1",  1'b0, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    // rotation
    step("rot0",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b00011, 1'b0, 2'd2, 12'h102, 3'd2);
    step("rot1",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b01100, 1'b0, 2'd2, 12'h408, 3'd4);
    step("rot2",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b10001, 1'b0, 2'd2, 12'h0A0, 3'd1);
    // single multiplier reservation
    step("mul0",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b00110, 1'b1, 2'd2, 12'h204, 3'd3);
    step("mul1",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b11000, 1'b0, 2'd2, 12'h810, 3'd0);
    step("mul2",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b00011, 1'b0, 2'd2, 12'h102, 3'd2);
    step("mul3",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b00100, 1'b0, 2'd1, 12'h201, 3'd3);
    // back-to-back multiplies
    step("b2b0",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b11000, 1'b1, 2'd2, 12'h810, 3'd0);
    step("b2b1",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b00011, 1'b1, 2'd2, 12'h102, 3'd2);
    step("b2b2",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b01100, 1'b1, 2'd2, 12'h408, 3'd4);
    step("b2b3",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1, 2'd1, 12'h801, 3'd0);
    step("b2b4",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 2'd1, 12'h081, 3'd1);
    step("b2b5",  1'b1, 5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1, 2'd1, 12'h101, 3'd2);
    // drain pending multiplies
    step("drn0",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b00100, 1'b0, 2'd1, 12'h201, 3'd3);
    step("drn1",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b01000, 1'b0, 2'd1, 12'h401, 3'd4);
    step("drn2",  1'b1, 5'b11111, 1'b0, 1'b0, 5'b10000, 1'b0, 2'd1, 12'h801, 3'd0);
    // flush two cycles after a multiplier grant, mult_req colliding with flush
    step("fl0",   1'b1, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 2'd2, 12'h000, 3'd0);
    step("fl1",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("fl2",   1'b1, 5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("fl3",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("fl4",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    // flush while a multiply is due next cycle
    step("fd0",   1'b1, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 2'd2, 12'h000, 3'd0);
    step("fd1",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("fd2",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("fd3",   1'b1, 5'b11111, 1'b0, 1'b1, 5'b00000, 1'b0, 2'd1, 12'h000, 3'd0);
    step("fd4",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    // sparse wrap
    step("sp0",   1'b1, 5'b00011, 1'b0, 1'b0, 5'b00011, 1'b0, 2'd2, 12'h102, 3'd2);
    step("sp1",   1'b1, 5'b00001, 1'b0, 1'b0, 5'b00001, 1'b0, 2'd2, 12'h002, 3'd1);
    step("sp2",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd1);
    // reset in the middle of a reservation
    step("mr0",   1'b1, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 2'd2, 12'h000, 3'd1);
    step("mr1",   1'b0, 5'b00100, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("mr2",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("mr3",   1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd2, 12'h000, 3'd0);
    step("mr4",   1'b1, 5'b00100, 1'b0, 1'b0, 5'b00100, 1'b0, 2'd2, 12'h008, 3'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cdb_slot_scheduler.md
# cdb_slot_scheduler

Allocates the `N` Common Data Bus slots one cycle ahead, ahead of the `cdb` broadcast register. Single-cycle FUs (ALU, branch, mem) are arbitrated at issue time. The pipelined multiplier's result slot is reserved `MULT_LAT` cycles in advance, so a multiply writeback never collides with a single-cycle writeback. Ungranted single-cycle requesters stall in issue. The registered select bus drives the CDB mux directly.

## Interface

- `N`, default 2: CDB width, in slots per cycle; must be ≥ 2.
- `NUM_REQ`, default 5: number of single-cycle requesters, equal to `NUM_FU_ALU+NUM_FU_BRANCH+NUM_FU_MEM`.
- `MULT_LAT`, default 4: cycles from multiplier issue to its CDB broadcast; must be ≥ 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `req` in `NUM_REQ`: requester j wants to issue now and broadcast next cycle.
- `mult_req` in 1: multiplier issue request this cycle.
- `flush` in 1: squash all pending multiplier reservations (mispredict recovery).
- `gnt` out `NUM_REQ`: combinational single-cycle grants; at most `free_slots` bits set.
- `mult_gnt` out 1: combinational multiplier grant.
- `free_slots` out `$clog2(N+1)`: number of next-cycle slots open to single-cycle FUs.
- `cdb_sel` out `[N][NUM_REQ+1]`: registered, one-hot-or-zero per slot. Bit 0 is the multiplier; bit j+1 is requester j.

## Operation

- State:
  - `resv[1..MULT_LAT-1]`: `resv[k]=1` means a multiply broadcasts in cycle t+k.
  - `rr_ptr` ∈ [0, `NUM_REQ`).
  - `cdb_sel` register.
- `free_slots = N - resv[1]`.
- `mult_gnt = mult_req & ~flush`. Its slot is always free, because no single-cycle grant reaches beyond t+1.
- Reservation shift each cycle:
  - `resv[k] <= resv[k+1]` for k < `MULT_LAT-1`.
  - `resv[MULT_LAT-1] <= mult_gnt`.
- Single-cycle grants:
  - Scan `req` from index `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - Grant the first `free_slots` asserted requests.
  - A requester that is not granted must hold `req` next cycle; the scheduler keeps no memory of it.
- Round-robin pointer:
  - If any grant is made, `rr_ptr <= (last granted index + 1) mod NUM_REQ`.
  - With no grants, `rr_ptr` holds.
- Next-cycle select `cdb_sel_next`:
  - If `resv[1]`, slot 0 takes bit 0 (multiplier).
  - Single-cycle grants then fill the lowest free slots, in scan order.
  - Unused slots are all-zero.
- Flush (`flush=1` at cycle t):
  - `gnt=0` and `mult_gnt=0` in cycle t.
  - All `resv` bits are 0 at t+1.
  - `cdb_sel` at t+1 is 0.
  - `rr_ptr` holds.
  - Exception: a multiply due in t+1 (`resv[1]`) is also squashed.
- Reset (`reset=0` at an edge):
  - `resv`, `rr_ptr` and `cdb_sel` clear to 0.
  - While `reset=0`, `gnt` and `mult_gnt` are forced to 0 and `free_slots` reads `N`.
  - Reset asserted mid-reservation discards all reservations.

## Timing

- Grant latency: 0 cycles. `gnt` and `mult_gnt` are combinational from `req`, `mult_req`, `resv` and `rr_ptr`.
- Broadcast latency:
  - A single-cycle grant at t appears in `cdb_sel` at t+1.
  - A multiplier grant at t appears in `cdb_sel` at t+`MULT_LAT`, always in slot 0.
- A multiplier granted at t reduces `free_slots` to N-1 at cycle t+`MULT_LAT`-1.
- Back-to-back multiplies are legal, one per cycle. In steady state this yields `free_slots = N-1` every cycle.
- `flush` and `mult_req` in the same cycle: flush wins; nothing is reserved.
- `free_slots` is valid from the cycle after reset deasserts.

## Structure

- Add the `CDB_SEL` typedef, `[N][NUM_FU_TOTAL]` bits, and the `MULT_LAT` constant to `sys_defs.svh`. Both are shared with `cdb` and the multiplier pipeline.
- One combinational sub-module, `rr_multi_sel`. Parameters: `WIDTH`, `SLOTS`. Inputs: `req`, `start`, `count`. Outputs: `gnt`, per-slot one-hot indices, `last` index, `any`.
- The top level holds `resv`, `rr_ptr`, the `cdb_sel` register and the flush/reset gating.

## Test plan

All scenarios use `N=2`, `NUM_REQ=5`, `MULT_LAT=4`.

- Reset: hold `reset=0` two cycles with `req=5'b11111`, `mult_req=1` -> `gnt=0`, `mult_gnt=0`, `cdb_sel=0`. First cycle after release -> `gnt=5'b00011`, next `rr_ptr=2`.
- Rotation: `req=5'b11111` held three cycles -> `gnt` = `00011`, `01100`, `10001`. Next cycle, `cdb_sel[0]` has bit 1 set and `cdb_sel[1]` has bit 2 set.
- Multiplier reservation: `mult_req=1` at t0 only, `req=5'b11111` continuous -> at t0+3, `free_slots=1` and exactly one `gnt` bit. At t0+4, `cdb_sel[0]=...0001` and `cdb_sel[1]` is one-hot on a requester.
- Back-to-back multiplies: `mult_req=1` every cycle from t0 -> `free_slots=1` from t0+3 onward. `cdb_sel[0][0]=1` every cycle from t0+4.
- Flush: multiplier granted at t0, `flush=1` at t0+2 -> `free_slots=2` at t0+3, `cdb_sel[*][0]=0` at t0+4. `rr_ptr` is unchanged across the flush cycle.
- Sparse wrap: `rr_ptr=2`, `req=5'b00001` -> `gnt=5'b00001`, `rr_ptr` becomes 1. Then `req=0` -> no grants, `rr_ptr` stays 1.
